// File: rtl/spi_slave.sv
// Byte-wide SPI target: SCLK idle high, launch on fall, sample on rise, MSB first.
// Define SPI_SLAVE_OVR_EN to enable the sticky rx_ovr overrun flag.
module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_ovr,
  output logic       busy
);
  typedef enum logic {IDLE, SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       rise_q, rise_d, fall_q, fall_d;
  logic       sclk_s, mosi_s, cs_s;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       reload, complete;
`ifdef SPI_SLAVE_OVR_EN
  logic       rx_ovr_q, rx_ovr_d;
`endif

  // Edge pulses are registered, so they trail the synchronized level by one clk.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    rise_d      = sclk_s & ~sclk_prev_q;
    fall_d      = ~sclk_s & sclk_prev_q;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    reload     = 1'b0;
    complete   = 1'b0;
`ifdef SPI_SLAVE_OVR_EN
    rx_ovr_d   = rx_ovr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          reload    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else if (rise_q) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            complete  = 1'b1;
            reload    = 1'b1;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (fall_q && bit_cnt_q != 3'd0) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    if (reload) begin
      tx_shift_d = tx_full_q ? tx_buf_q : IDLE_BYTE;
      tx_full_d  = 1'b0;
    end
    // A same-cycle load lands in the buffer after the reload drained it.
    if (tx_load) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    if (rx_ack) begin
      rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_OVR_EN
      rx_ovr_d   = 1'b0;
`endif
    end
    if (complete) begin
      rx_data_d  = {rx_shift_q[6:0], mosi_s};
      rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_OVR_EN
      if (rx_valid_q && !rx_ack) rx_ovr_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_prev_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      tx_buf_q    <= 8'h00;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_ovr_q <= 1'b0;
    else      rx_ovr_q <= rx_ovr_d;
  end
  assign rx_ovr = rx_ovr_q;
`else
  assign rx_ovr = 1'b0;
`endif

  assign miso     = (state_q == SHIFT) ? tx_shift_q[7] : 1'b1;
  assign busy     = (state_q == SHIFT);
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: an SPI master drives frames, a transaction-level
// model tracks the TX buffer, expected returned bytes and rx_valid / rx_ovr.
module tb_spi_slave;
  localparam int HP = 8;
`ifdef SPI_SLAVE_OVR_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic sclk = 1'b1, mosi = 1'b0, cs_n = 1'b1;
  logic miso, tx_ready, rx_valid, rx_ovr, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic tx_load = 1'b0, rx_ack = 1'b0;

  int pass_cnt = 0, tot_cnt = 0;

  // Transaction-level model state
  logic       m_full = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_buf = 8'h00, m_next = 8'hFF, m_rx = 8'h00;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_ovr(rx_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_take();
    logic [7:0] b;
    b = m_full ? m_buf : 8'hFF;
    m_full = 1'b0;
    return b;
  endfunction

  task automatic load(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    m_buf = d; m_full = 1'b1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    m_next = m_take();
    wait_clk(HP);
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    wait_clk(HP);
  endtask

  // One full byte. With ack_last, rx_ack pulses in the exact clk the byte completes.
  task automatic spi_byte(input logic [7:0] tx, input bit ack_last,
                          output logic [7:0] rx, output logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0; mosi = tx[i];
      wait_clk(HP);
      sclk = 1'b1; rx[i] = miso;
      if (ack_last && i == 0) begin
        wait_clk(3); rx_ack = 1'b1;
        wait_clk(1); rx_ack = 1'b0;
        wait_clk(HP - 4);
      end else begin
        wait_clk(HP);
      end
    end
    exp = m_next;
    if (ack_last) m_ovr = 1'b0;
    else if (m_valid && OVR) m_ovr = 1'b1;
    m_valid = 1'b1; m_rx = tx;
    m_next = m_take();
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] r, e, b;
    wait_clk(3);
    tot_cnt++; if (miso !== 1'b1) $display("FAIL reset_miso got=%b exp=1", miso); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    tot_cnt++; if ({rx_valid, rx_ovr, tx_ready, busy} !== 4'b0010)
      $display("FAIL reset_flags got=%b exp=0010", {rx_valid, rx_ovr, tx_ready, busy}); else pass_cnt++;
    rst = 1'b1;
    wait_clk(4);
    // Mid-byte reset after three rises
    load(8'h5A);
    frame_begin();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b0; mosi = 1'b1; wait_clk(HP);
      sclk = 1'b1; wait_clk(HP);
    end
    sclk = 1'b0; wait_clk(2);
    rst = 1'b0; #1;
    model_reset();
    tot_cnt++; if ({miso, rx_valid, rx_ovr, tx_ready, busy} !== 5'b10010)
      $display("FAIL midreset_flags got=%b exp=10010", {miso, rx_valid, rx_ovr, tx_ready, busy}); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'h00) $display("FAIL midreset_rx_data got=%h exp=00", rx_data); else pass_cnt++;
    sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    b = 8'($urandom);
    frame_begin(); spi_byte(b, 1'b0, r, e); frame_end();
    tot_cnt++; if (r !== e) $display("FAIL postreset_miso got=%h exp=%h", r, e); else pass_cnt++;
    tot_cnt++; if (rx_data !== b || rx_valid !== 1'b1)
      $display("FAIL postreset_rx got=%h/%b exp=%h/1", rx_data, rx_valid, b); else pass_cnt++;
    ack();
  endtask

  task automatic test_tx_load();
    logic [7:0] r, e;
    load(8'hA5);
    tot_cnt++; if (tx_ready !== 1'b0) $display("FAIL load_tx_ready got=%b exp=0", tx_ready); else pass_cnt++;
    frame_begin(); spi_byte(8'h3C, 1'b0, r, e); frame_end();
    tot_cnt++; if (r !== 8'hA5 || e !== 8'hA5) $display("FAIL load_miso got=%h exp=a5", r); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'h3C || rx_valid !== 1'b1 || tx_ready !== 1'b1)
      $display("FAIL load_rx got=%h/%b/%b exp=3c/1/1", rx_data, rx_valid, tx_ready); else pass_cnt++;
    ack();
    frame_begin(); spi_byte(8'h81, 1'b0, r, e); frame_end();
    tot_cnt++; if (r !== 8'hFF) $display("FAIL idle_miso got=%h exp=ff", r); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'h81) $display("FAIL idle_rx_data got=%h exp=81", rx_data); else pass_cnt++;
    ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, e1, r2, e2, b;
    b = 8'($urandom);
    load(b);
    frame_begin();
    load(8'h56);
    spi_byte(8'h12, 1'b0, r1, e1);
    spi_byte(8'h34, 1'b0, r2, e2);
    frame_end();
    tot_cnt++; if (r1 !== b || r1 !== e1) $display("FAIL b2b_miso1 got=%h exp=%h", r1, b); else pass_cnt++;
    tot_cnt++; if (r2 !== 8'h56 || r2 !== e2) $display("FAIL b2b_miso2 got=%h exp=56", r2); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'h34 || rx_valid !== 1'b1)
      $display("FAIL b2b_rx got=%h/%b exp=34/1", rx_data, rx_valid); else pass_cnt++;
    tot_cnt++; if (rx_ovr !== OVR) $display("FAIL b2b_ovr got=%b exp=%b", rx_ovr, OVR); else pass_cnt++;
    ack();
    tot_cnt++; if (rx_valid !== 1'b0 || rx_ovr !== 1'b0)
      $display("FAIL b2b_ack got=%b/%b exp=0/0", rx_valid, rx_ovr); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [7:0] r, e;
    load(8'($urandom));
    frame_begin();
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0; mosi = 1'($urandom); wait_clk(HP);
      sclk = 1'b1; wait_clk(HP);
    end
    frame_end();
    tot_cnt++; if ({rx_valid, busy, tx_ready} !== 3'b001)
      $display("FAIL abort_flags got=%b exp=001", {rx_valid, busy, tx_ready}); else pass_cnt++;
    tot_cnt++; if (dut.bit_cnt_q !== 3'd0) $display("FAIL abort_bit_cnt got=%0d exp=0", dut.bit_cnt_q); else pass_cnt++;
    frame_begin(); spi_byte(8'hC3, 1'b0, r, e); frame_end();
    tot_cnt++; if (r !== 8'hFF || e !== 8'hFF) $display("FAIL abort_lost_tx got=%h exp=ff", r); else pass_cnt++;
    tot_cnt++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1)
      $display("FAIL abort_next_rx got=%h/%b exp=c3/1", rx_data, rx_valid); else pass_cnt++;
  endtask

  // Entered with rx_valid still set, so an ack that won would drop it.
  task automatic test_ack_coincident();
    logic [7:0] r, e, b;
    b = 8'($urandom);
    frame_begin(); spi_byte(b, 1'b1, r, e);
    tot_cnt++; if (rx_valid !== 1'b1 || rx_ovr !== 1'b0)
      $display("FAIL ackcoin_flags got=%b/%b exp=1/0", rx_valid, rx_ovr); else pass_cnt++;
    frame_end();
    tot_cnt++; if (rx_data !== b) $display("FAIL ackcoin_rx_data got=%h exp=%h", rx_data, b); else pass_cnt++;
    ack();
  endtask

  task automatic test_random();
    logic [7:0] r, e, b;
    int n;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(1, 0) == 1) ack();
      if ($urandom_range(1, 0) == 1) load(8'($urandom));
      n = $urandom_range(2, 1);
      frame_begin();
      for (int k = 0; k < n; k++) begin
        if (k == 1 && $urandom_range(1, 0) == 1) load(8'($urandom));
        b = 8'($urandom);
        spi_byte(b, 1'b0, r, e);
        tot_cnt++; if (r !== e) $display("FAIL rand_miso it=%0d got=%h exp=%h", it, r, e); else pass_cnt++;
      end
      frame_end();
      tot_cnt++; if ({rx_data, rx_valid, rx_ovr, tx_ready} !== {m_rx, m_valid, m_ovr, ~m_full})
        $display("FAIL rand_state it=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", it,
                 rx_data, rx_valid, rx_ovr, tx_ready, m_rx, m_valid, m_ovr, ~m_full);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_load();
    test_back_to_back();
    test_abort();
    test_ack_coincident();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-wide SPI peripheral (target) for the far end of the design's 8-bit SPI master link: SCLK idles high, data launched on SCLK falling edge, sampled on rising edge, MSB first. It oversamples `sclk`, `mosi`, `cs_n` on the system clock, shifts received bits into `rx_data` and returns a host-loaded byte on `miso`. It sits between the pad/interconnect side of an SPI bus and a local register file or FIFO.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `mosi`, `cs_n` (≥2).
- `IDLE_BYTE`, 8'hFF: byte shifted out when no host byte is pending.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `mosi` in 1: master-out data.
- `cs_n` in 1: chip select, active-low, frames transfers.
- `miso` out 1: slave-out data.
- `tx_data` in 8: next byte to return.
- `tx_load` in 1: one-cycle strobe; captures `tx_data` into TX buffer.
- `tx_ready` out 1: TX buffer empty.
- `rx_data` out 8: last complete received byte.
- `rx_valid` out 1: `rx_data` holds an unacknowledged byte.
- `rx_ack` in 1: clears `rx_valid`.
- `rx_ovr` out 1: sticky overrun flag (see Configuration).
- `busy` out 1: `cs_n` asserted (state SHIFT).

## Operation
- Synchronizers: reset values `sclk`=1, `cs_n`=1, `mosi`=0. Edge detect on synchronized `sclk` (rise/fall pulses, one `clk` each).
- States: IDLE (sync `cs_n`=1), SHIFT (sync `cs_n`=0).
- IDLE→SHIFT on sync `cs_n` falling: `tx_shift` ← TX buffer if full (buffer marked empty) else `IDLE_BYTE`; `bit_cnt` ← 0.
- `miso` = `tx_shift[7]` in SHIFT, 1 in IDLE.
- SCLK rise in SHIFT: `rx_shift` ← {`rx_shift[6:0]`, `mosi`}; `bit_cnt` +1.
- SCLK fall in SHIFT with `bit_cnt` in 1..7: `tx_shift` ← `tx_shift` << 1. Fall with `bit_cnt`=0 leaves `tx_shift` unchanged (bit 7 already on `miso`).
- Eighth rise: `rx_data` ← {`rx_shift[6:0]`, `mosi`}, `rx_valid` ← 1, `bit_cnt` ← 0, `tx_shift` reloaded as on entry (back-to-back bytes within one `cs_n` frame).
- SHIFT→IDLE on sync `cs_n` rising, any `bit_cnt`: partial byte discarded, no `rx_valid`, `bit_cnt` ← 0. A TX byte consumed by the aborted byte is lost.
- `tx_load` while buffer full: overwrites buffer. `tx_load` in the same cycle as a reload: reload takes old buffer content (or `IDLE_BYTE`), new byte lands in buffer, `tx_ready`=0.
- `rx_ack` with byte completion in the same cycle: completion wins, `rx_valid` stays 1, no overrun.
- Reset (any time, including mid-byte): state IDLE, `miso`=1, `rx_data`=8'h00, `rx_valid`=0, `rx_ovr`=0, `tx_ready`=1, `busy`=0, counters and shifters zero.

## Timing
- Input-to-internal latency: `SYNC_STAGES`+1 `clk` cycles from pin edge to edge pulse.
- `miso` updates 1 `clk` after the fall pulse: `SYNC_STAGES`+2 cycles after pin falling edge.
- `rx_valid` rises 1 `clk` after the eighth rise pulse.
- Requirement on master: SCLK high and low phases each ≥ `SYNC_STAGES`+3 `clk` cycles; `cs_n` setup to first SCLK fall and hold after last rise ≥ `SYNC_STAGES`+2 cycles. The codebase master (8-cycle half period) meets this at default depth.
- `tx_ready` reflects buffer state 1 `clk` after `tx_load` or reload.

## Configuration
- `SPI_SLAVE_OVR_EN` defined: byte completion while `rx_valid`=1 (and no same-cycle `rx_ack`) overwrites `rx_data` and sets `rx_ovr`; `rx_ovr` cleared by `rx_ack` or reset.
- Undefined: `rx_ovr` tied 0, no overrun logic; `rx_data` still overwritten.

## Test plan
- Reset low mid-byte (after 3 rises) -> all outputs at reset values immediately; next frame receives cleanly.
- `tx_load` 8'hA5, frame with master sending 8'h3C -> master receives 8'hA5; `rx_data`=8'h3C, `rx_valid`=1, `tx_ready`=1.
- No `tx_load`, one byte 8'h81 -> master receives 8'hFF; `rx_data`=8'h81.
- Two back-to-back bytes 8'h12, 8'h34 in one `cs_n` frame, TX buffer refilled with 8'h56 before byte 2 -> master sees buffer byte then 8'h56; with macro and no `rx_ack`, `rx_data`=8'h34, `rx_ovr`=1.
- `cs_n` deasserted after 5 bits -> `rx_valid` stays 0, `bit_cnt`=0, `busy`=0; next full byte 8'hC3 received correctly.
- `rx_ack` coincident with byte-complete -> `rx_valid` remains 1, `rx_ovr`=0.
